// File: rtl/axis_byte_fifo.sv
// First-word-fall-through AXI4-Stream FIFO with registered upstream ready and fill level.
// Defining AXIS_FIFO_STATS_EN adds stat_bytes / stat_hiwm / stat_stalls counters.
module axis_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [ADDR_W:0]   level
`ifdef AXIS_FIFO_STATS_EN
    ,
    output logic [31:0]       stat_bytes,
    output logic [ADDR_W:0]   stat_hiwm,
    output logic [15:0]       stat_stalls
`endif
);

    // Handshake: a beat moves on a rising edge only when valid & ready are both high;
    // valid never waits on ready, and a source holding valid keeps its data stable.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   wr_ptr_nxt;
    logic [ADDR_W:0]   rd_ptr_nxt;
    logic [ADDR_W:0]   level_nxt;
    logic              push;
    logic              pop;
    logic              full_nxt;

    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = (wr_ptr != rd_ptr);
    assign m_axis_tdata  = mem[rd_ptr[ADDR_W-1:0]];

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push};
        rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        full_nxt   = (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                     (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
    end

    // Ready is derived from next-state pointers so it never sees m_axis_tready combinationally.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            level         <= level_nxt;
            s_axis_tready <= !full_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !areset) begin
            mem[wr_ptr[ADDR_W-1:0]] <= s_axis_tdata;
        end
    end

`ifdef AXIS_FIFO_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_bytes  <= '0;
            stat_hiwm   <= '0;
            stat_stalls <= '0;
        end else begin
            stat_bytes <= stat_bytes + {31'd0, push};
            if (level_nxt > stat_hiwm) begin
                stat_hiwm <= level_nxt;
            end
            if (s_axis_tvalid && !s_axis_tready && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_byte_fifo.sv
// Directed bench for axis_byte_fifo: vector table for reset/single/fill/drain,
// then model-checked concurrency and random back-pressure sequences.
`timescale 1ns/1ps
module tb_axis_byte_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              aclk = 1'b0;
    logic              areset;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [ADDR_W:0]   level;
`ifdef AXIS_FIFO_STATS_EN
    logic [31:0]       stat_bytes;
    logic [ADDR_W:0]   stat_hiwm;
    logic [15:0]       stat_stalls;
`endif

    axis_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .level         (level)
`ifdef AXIS_FIFO_STATS_EN
        ,
        .stat_bytes    (stat_bytes),
        .stat_hiwm     (stat_hiwm),
        .stat_stalls   (stat_stalls)
`endif
    );

    // clock / watchdog
    always #5 aclk = ~aclk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [DATA_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int mdl_cnt  = 0;
    int mdl_max  = 0;
    int mdl_push = 0;
    int mdl_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h5A;
        m_axis_tready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("rst_s_tready", 32'(s_axis_tready), 32'd0);
            check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
            check("rst_level", 32'(level), 32'd0);
        end
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        check("post_rst_s_tready", 32'(s_axis_tready), 32'd1);
        check("post_rst_level", 32'(level), 32'd0);
        exp_q.delete();
        mdl_cnt   = 0;
        mdl_max   = 0;
        mdl_push  = 0;
        mdl_stall = 0;
`ifdef AXIS_FIFO_STATS_EN
        check("rst_stat_bytes", stat_bytes, 32'd0);
        check("rst_stat_stalls", 32'(stat_stalls), 32'd0);
`endif
    endtask

    // One model-checked cycle; called at #1 after an edge.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic r);
        logic push;
        logic pop;
        push = v && (mdl_cnt < DEPTH);
        pop  = r && (mdl_cnt > 0);
        if (v && mdl_cnt == DEPTH && mdl_stall < 16'hFFFF) mdl_stall++;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("pop_data", 32'(m_axis_tdata), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (push) begin
            exp_q.push_back(d);
            mdl_push++;
        end
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = r;
        tick();
        mdl_cnt = mdl_cnt + int'(push) - int'(pop);
        if (mdl_cnt > mdl_max) mdl_max = mdl_cnt;
        check("mdl_level", 32'(level), 32'(mdl_cnt));
        check("mdl_s_tready", 32'(s_axis_tready), 32'(mdl_cnt != DEPTH));
        check("mdl_m_tvalid", 32'(m_axis_tvalid), 32'(mdl_cnt != 0));
    endtask

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       e_sr;
        logic       e_mv;
        logic [7:0] e_md;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t vecs[22];

    initial begin
        int cyc;
        // vector table: values expected right after the edge the inputs are applied to
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0};
        for (int i = 0; i < 16; i++) begin
            vecs[2+i] = '{1'b1, 8'(i), 1'b0, (i < 15), 1'b1, 8'h00, 5'(i + 1)};
        end
        vecs[18] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h00, 5'd16};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 5'd15};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 5'd15};
        vecs[21] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 8'h02, 5'd15};

        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        do_reset(3);

        for (int i = 0; i < 22; i++) begin
            s_axis_tvalid = vecs[i].sv;
            s_axis_tdata  = vecs[i].sd;
            m_axis_tready = vecs[i].mr;
            tick();
            check($sformatf("vec%0d_s_tready", i), 32'(s_axis_tready), 32'(vecs[i].e_sr));
            check($sformatf("vec%0d_m_tvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_mv));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d_m_tdata", i), 32'(m_axis_tdata), 32'(vecs[i].e_md));
            end
        end

        // Drain the 15 held words: the ignored 8'hEE must not appear.
        mdl_cnt = 15;
        mdl_max = 16;
        for (int i = 2; i <= 16; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 15; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Concurrent push/pop with random data.
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        end
        check("conc_level", 32'(level), 32'd1);

        // Mid-operation reset discards the held word.
        do_reset(1);
        check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Random back-pressure, 10000 bytes.
        cyc = 0;
        while (mdl_push < 10000 && cyc < 60000) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)));
            cyc++;
        end
        check("rand_bytes_pushed", 32'(mdl_push), 32'd10000);
        cyc = 0;
        while (mdl_cnt > 0 && cyc < 100) begin
            drive_cycle(1'b0, 8'h00, 1'b1);
            cyc++;
        end
        check("rand_drain_empty", 32'(exp_q.size()), 32'd0);
        check("rand_final_level", 32'(level), 32'd0);
`ifdef AXIS_FIFO_STATS_EN
        check("stat_bytes", stat_bytes, 32'(mdl_push));
        check("stat_hiwm", 32'(stat_hiwm), 32'(mdl_max));
        check("stat_stalls", 32'(stat_stalls), 32'(mdl_stall));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
